// File: rtl/tmds_pkg.sv
// tmds_pkg
// Shared TMDS definitions for the encoder and decoder sides of a channel:
// the four control tokens, the word-alignment FSM state type and the
// symbol decode helpers.
//   tmds_decode_data : 10-bit data symbol -> 8-bit byte
//   tmds_ctrl_match  : 10-bit word -> {valid, {v,h}} for exact token matches
package tmds_pkg;

    // Bit 0 is the first bit on the wire; literals are written MSB first.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] vh;      // {vsync, hsync}
    } ctrl_match_t;

    // Undo the optional inversion (q[9]) and then the XOR/XNOR chain (q[8]).
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
        logic [7:0] t;
        logic [7:0] d;
        t    = q[9] ? ~q[7:0] : q[7:0];
        d    = 8'h00;
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

    function automatic ctrl_match_t tmds_ctrl_match(input logic [9:0] q);
        ctrl_match_t m;
        m.valid = 1'b1;
        m.vh    = 2'b00;
        case (q)
            CTRL_TOKEN_00: m.vh = 2'b00;
            CTRL_TOKEN_01: m.vh = 2'b01;
            CTRL_TOKEN_10: m.vh = 2'b10;
            CTRL_TOKEN_11: m.vh = 2'b11;
            default:       m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// tmds_word_align
// Word-boundary hunting FSM. Counts consecutive control tokens to declare
// lock, requests a one-bit slip from the deserializer when a search window
// passes without a qualifying run, and drops lock when a window passes
// without any control token.
// Ports:
//   clk_pixel  in   pixel clock
//   reset_n    in   asynchronous active-low reset
//   ctrl_i     in   the word currently classified is a control token
//   locked_o   out  registered: word alignment established
//   bitslip_o  out  registered one-cycle slip request (no acknowledge)
//   state_o    out  current FSM state, for debug/observation
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT    = 16,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_WAIT     = 8
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic         ctrl_i,
    output logic         locked_o,
    output logic         bitslip_o,
    output align_state_e state_o
);

    localparam int RUN_W  = $clog2(LOCK_COUNT) + 1;
    localparam int TMR_W  = $clog2(SEARCH_WINDOW) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_COUNT);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_WINDOW - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = '1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    align_state_e      state_q, state_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [TMR_W-1:0]  gap_tmr_q, gap_tmr_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              locked_q, locked_d;
    logic              bitslip_q, bitslip_d;
    logic [RUN_W-1:0]  run_next;

    // Run length including the word classified this cycle, so lock is
    // registered on the same edge that closes the qualifying run.
    always_comb begin
        run_next = '0;
        if (ctrl_i) begin
            run_next = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SEARCH;
            run_cnt_q  <= '0;
            tmr_q      <= '0;
            gap_tmr_q  <= '0;
            wait_cnt_q <= '0;
            locked_q   <= 1'b0;
            bitslip_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            tmr_q      <= tmr_d;
            gap_tmr_q  <= gap_tmr_d;
            wait_cnt_q <= wait_cnt_d;
            locked_q   <= locked_d;
            bitslip_q  <= bitslip_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        tmr_d      = tmr_q;
        gap_tmr_d  = gap_tmr_q;
        wait_cnt_d = wait_cnt_q;
        locked_d   = locked_q;
        bitslip_d  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                run_cnt_d = run_next;
                tmr_d     = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
                // Lock wins over the window expiring in the same cycle.
                if (run_next == RUN_MAX) begin
                    state_d   = ST_LOCKED;
                    locked_d  = 1'b1;
                    run_cnt_d = '0;
                    gap_tmr_d = '0;
                    tmr_d     = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d    = ST_SLIP;
                    bitslip_d  = 1'b1;
                    run_cnt_d  = '0;
                    wait_cnt_d = '0;
                    tmr_d      = '0;
                end
            end
            ST_SLIP: begin
                // The deserializer is re-framing; words seen here are ignored.
                run_cnt_d = '0;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_SEARCH;
                    wait_cnt_d = '0;
                    tmr_d      = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                run_cnt_d = run_next;
                if (ctrl_i) begin
                    gap_tmr_d = '0;
                end else if (gap_tmr_q == TMR_LAST) begin
                    // Lost alignment: fall back to searching at the current
                    // boundary first, without slipping.
                    state_d   = ST_SEARCH;
                    locked_d  = 1'b0;
                    run_cnt_d = '0;
                    gap_tmr_d = '0;
                    tmr_d     = '0;
                end else begin
                    gap_tmr_d = (gap_tmr_q == TMR_MAX) ? gap_tmr_q : gap_tmr_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                locked_d  = 1'b0;
                run_cnt_d = '0;
                tmr_d     = '0;
            end
        endcase
    end

    assign locked_o  = locked_q;
    assign bitslip_o = bitslip_q;
    assign state_o   = state_q;

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder
// Per-channel TMDS receive decoder. Stage 1 registers the incoming symbol
// and classifies it; stage 2 registers the decoded byte or sync pair.
// Latency from in_i to data_o/de_o/hsync_o/vsync_o is two clk_pixel edges.
// Ports:
//   clk_pixel  in   pixel clock
//   reset_n    in   asynchronous active-low reset
//   in_i       in   10-bit received symbol, bit 0 first on the wire
//   data_o     out  decoded byte, valid when de_o=1
//   de_o       out  data enable
//   hsync_o    out  decoded hsync (held across data periods)
//   vsync_o    out  decoded vsync (held across data periods)
//   locked_o   out  word alignment established
//   bitslip_o  out  one-cycle request to shift the word boundary by one bit
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT    = 16,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_WAIT     = 8
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] in_i,
    output logic [7:0] data_o,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       locked_o,
    output logic       bitslip_o
);

    logic [9:0]   sym_q;
    logic [7:0]   data_q, data_d;
    logic         de_q, de_d;
    logic         hsync_q, hsync_d;
    logic         vsync_q, vsync_d;
    ctrl_match_t  match;
    logic [7:0]   dec_byte;
    align_state_e align_state;

    assign match    = tmds_ctrl_match(sym_q);
    assign dec_byte = tmds_decode_data(sym_q);

    tmds_word_align #(
        .LOCK_COUNT    (LOCK_COUNT),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .SLIP_WAIT     (SLIP_WAIT)
    ) u_align (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .ctrl_i    (match.valid),
        .locked_o  (locked_o),
        .bitslip_o (bitslip_o),
        .state_o   (align_state)
    );

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            sym_q   <= '0;
            data_q  <= '0;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            sym_q   <= in_i;
            data_q  <= data_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // LOCKED state is registered on the same edge as locked_o, so gating on
    // it is the same as gating on the lock flag seen during classification.
    always_comb begin
        data_d  = 8'h00;
        de_d    = 1'b0;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (align_state == ST_LOCKED) begin
            if (match.valid) begin
                {vsync_d, hsync_d} = match.vh;
            end else begin
                de_d   = 1'b1;
                data_d = dec_byte;
            end
        end
    end

    assign data_o  = data_q;
    assign de_o    = de_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder
// Directed-plus-random bench for tmds_decoder. Expected outputs come from a
// small spec-level model: data bytes are produced by a forward TMDS encoder
// and must come back unchanged; lock follows "16 tokens in a row" and
// "SEARCH_WINDOW data words in a row" rules.
module tb_tmds_decoder;

    localparam int LOCK_COUNT    = 16;
    localparam int SEARCH_WINDOW = 4096;
    localparam int SLIP_WAIT     = 8;

    // ---------------- clock / reset ----------------
    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b1;
    logic [9:0] in_i      = 10'h000;
    logic [7:0] data_o;
    logic       de_o, hsync_o, vsync_o, locked_o, bitslip_o;

    always #5 clk_pixel = ~clk_pixel;

    tmds_decoder #(
        .LOCK_COUNT    (LOCK_COUNT),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .SLIP_WAIT     (SLIP_WAIT)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .in_i      (in_i),
        .data_o    (data_o),
        .de_o      (de_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .locked_o  (locked_o),
        .bitslip_o (bitslip_o)
    );

    // ---------------- scoreboard state ----------------
    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    logic [9:0]  tok [4];            // index is {v,h}
    logic [10:0] exp_q [$];          // {de, v, h, data}
    bit          m_locked;
    int          m_run;
    int          m_gap;
    logic        m_h, m_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tok_index(input logic [9:0] w);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (w == tok[i]) r = i;
        return r;
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
        logic [9:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
        return r;
    endfunction

    // Forward TMDS encode with free choice of XOR/XNOR and inversion.
    task automatic rand_data(output logic [9:0] w, output logic [7:0] d);
        logic [7:0] qm;
        bit         use_xor, inv;
        d       = 8'($urandom);
        use_xor = 1'($urandom_range(1));
        inv     = 1'($urandom_range(1));
        qm[0]   = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        w = {inv, use_xor, inv ? ~qm : qm};
        if (tok_index(w) >= 0) w = {~inv, use_xor, inv ? qm : ~qm};
    endtask

    task automatic model_clear();
        m_locked = 1'b0;
        m_run    = 0;
        m_gap    = 0;
        m_h      = 1'b0;
        m_v      = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_i    = 10'h000;
        reset_n = 1'b0;
        #2;
        check("rst_data", data_o, 0);
        check("rst_de", de_o, 0);
        check("rst_hsync", hsync_o, 0);
        check("rst_vsync", vsync_o, 0);
        check("rst_locked", locked_o, 0);
        check("rst_bitslip", bitslip_o, 0);
        @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    // Drive one word; after the capturing edge, check the previous word's
    // outputs and the lock flag that applies to this word.
    task automatic send(input logic [9:0] w, input logic [7:0] d_exp);
        int          ti;
        logic [10:0] e;
        in_i = w;
        @(posedge clk_pixel);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("de", de_o, e[10]);
            check("vsync", vsync_o, e[9]);
            check("hsync", hsync_o, e[8]);
            check("data", data_o, e[7:0]);
        end
        check("locked", locked_o, m_locked);
        check("bitslip", bitslip_o, 0);
        ti = tok_index(w);
        if (m_locked) begin
            if (ti >= 0) begin
                m_v   = ti[1];
                m_h   = ti[0];
                m_gap = 0;
                e     = {1'b0, m_v, m_h, 8'h00};
            end else begin
                e = {1'b1, m_v, m_h, d_exp};
                m_gap++;
                if (m_gap == SEARCH_WINDOW) begin
                    m_locked = 1'b0;
                    m_run    = 0;
                    m_gap    = 0;
                end
            end
        end else begin
            e = {1'b0, m_v, m_h, 8'h00};
            if (ti >= 0) begin
                m_run++;
                if (m_run == LOCK_COUNT) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                    m_gap    = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] w;
        logic [7:0] d;
        int         off, n, pulses, hi_cycles, lock_edge;
        int         pe [3];
        logic       prev_slip;

        tok[0] = 10'b1101010100;
        tok[1] = 10'b0010101011;
        tok[2] = 10'b0101010100;
        tok[3] = 10'b1010101011;
        model_clear();
        #3;

        // 1: aligned tokens give lock after 16
        do_reset();
        for (int k = 0; k < 20; k++) send(tok[0], 8'h00);

        // 2: fixed data words, then a random mix of data and tokens
        send(10'h100, 8'h00);
        send(10'h200, 8'hFF);
        send(tok[3], 8'h00);
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(3) == 0) begin
                send(tok[$urandom_range(3)], 8'h00);
            end else begin
                rand_data(w, d);
                send(w, d);
            end
        end

        // 3: misaligned by 3 bits, bench deserializer un-rotates per slip
        do_reset();
        off       = 3;
        n         = 0;
        pulses    = 0;
        hi_cycles = 0;
        lock_edge = -1;
        prev_slip = 1'b0;
        pe[0] = 0; pe[1] = 0; pe[2] = 0;
        while (lock_edge < 0 && n < 4 * (SEARCH_WINDOW + SLIP_WAIT) + 200) begin
            in_i = rotl(tok[1], off);
            @(posedge clk_pixel);
            #1;
            n++;
            if (bitslip_o === 1'b1) begin
                hi_cycles++;
                if (!prev_slip) begin
                    if (pulses < 3) pe[pulses] = n;
                    pulses++;
                    if (off > 0) off--;
                end
            end
            prev_slip = (bitslip_o === 1'b1);
            if (locked_o === 1'b1) lock_edge = n;
        end
        check("slip_pulses", pulses, 3);
        check("slip_high_cycles", hi_cycles, 3);
        check("slip1_edge", pe[0], SEARCH_WINDOW);
        check("slip_gap12", pe[1] - pe[0], SEARCH_WINDOW + SLIP_WAIT);
        check("slip_gap23", pe[2] - pe[1], SEARCH_WINDOW + SLIP_WAIT);
        check("lock_edge", lock_edge, pe[2] + SLIP_WAIT + LOCK_COUNT);
        @(posedge clk_pixel);
        #1;
        check("t3_hsync", hsync_o, 1);
        check("t3_vsync", vsync_o, 0);
        check("t3_de", de_o, 0);
        check("t3_locked", locked_o, 1);
        exp_q.delete();
        m_locked = 1'b1;
        m_h      = 1'b1;
        m_v      = 1'b0;
        m_gap    = 0;
        m_run    = 0;

        // 4: a full window of data drops lock, tokens relock
        for (int k = 0; k < SEARCH_WINDOW; k++) send(10'h100, 8'h00);
        for (int k = 0; k < 18; k++) send(tok[2], 8'h00);

        // 5: a data word inside the run restarts the count
        do_reset();
        for (int k = 0; k < 15; k++) send(tok[$urandom_range(3)], 8'h00);
        send(10'h100, 8'h00);
        for (int k = 0; k < 15; k++) send(tok[$urandom_range(3)], 8'h00);
        send(tok[1], 8'h00);
        send(tok[3], 8'h00);
        send(tok[3], 8'h00);

        // 6: reset in the middle of a data period
        for (int k = 0; k < 5; k++) begin
            rand_data(w, d);
            send(w, d);
        end
        do_reset();
        for (int k = 0; k < 16; k++) send(tok[2], 8'h00);
        for (int k = 0; k < 3; k++) begin
            rand_data(w, d);
            send(w, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
